// File: rtl/counter_vector_param.sv
// -----------------------------------------------------------------------------
// counter_vector_param
//
// Parametrised up/down counter with programmable width and modulus. The count
// runs modulo MAX+1 and either wraps or saturates at the boundaries. A
// registered terminal-count pulse marks every boundary event, and a sticky
// overflow flag records that at least one boundary event has occurred since
// the last clear. All outputs come directly from flops.
//
// Parameters:
//   WIDTH    : counter width in bits (1..32)
//   MAX      : terminal (highest) count, 1 <= MAX <= 2**WIDTH-1
//   SATURATE : 0 = wrap at the boundaries, 1 = hold at the boundaries
//
// Ports:
//   CLK      in   1      clock, rising edge active
//   RESET_N  in   1      asynchronous active-low reset
//   EN       in   1      count enable, one step per enabled cycle
//   DIR      in   1      0 = up, 1 = down
//   CLR      in   1      synchronous clear of C, TC and OVF (highest priority)
//   LOAD     in   1      synchronous load of min(D, MAX) into C
//   D        in   WIDTH  load value
//   OVF_CLR  in   1      synchronous clear of OVF (a same-edge event wins)
//   C        out  WIDTH  current count
//   TC       out  1      terminal-count pulse
//   OVF      out  1      sticky boundary-event flag
// -----------------------------------------------------------------------------
module counter_vector_param #(
  parameter int unsigned      WIDTH    = 8,
  parameter logic [WIDTH-1:0] MAX      = {WIDTH{1'b1}},
  parameter bit               SATURATE = 1'b0
) (
  input  logic             CLK,
  input  logic             RESET_N,
  input  logic             EN,
  input  logic             DIR,
  input  logic             CLR,
  input  logic             LOAD,
  input  logic [WIDTH-1:0] D,
  input  logic             OVF_CLR,
  output logic [WIDTH-1:0] C,
  output logic             TC,
  output logic             OVF
);

  logic [WIDTH-1:0] r_c;
  logic             r_tc;
  logic             r_ovf;

  logic [WIDTH-1:0] w_c_nxt;
  logic             w_tc_nxt;
  logic             w_ovf_nxt;
  logic [WIDTH-1:0] w_d_clamp;
  logic             w_at_max;
  logic             w_at_zero;

  assign w_at_max  = (r_c == MAX);
  assign w_at_zero = (r_c == '0);
  // A load never lets the count leave the 0..MAX range.
  assign w_d_clamp = (D > MAX) ? MAX : D;

  always_comb begin
    w_c_nxt   = r_c;
    w_tc_nxt  = 1'b0;
    // OVF_CLR is applied first so that a boundary event below overrides it.
    w_ovf_nxt = r_ovf & ~OVF_CLR;

    if (CLR) begin
      w_c_nxt   = '0;
      w_ovf_nxt = 1'b0;
    end else if (LOAD) begin
      w_c_nxt = w_d_clamp;
    end else if (EN) begin
      if (!DIR) begin
        if (w_at_max) begin
          w_tc_nxt  = 1'b1;
          w_ovf_nxt = 1'b1;
          w_c_nxt   = SATURATE ? MAX : '0;
        end else begin
          w_c_nxt = r_c + WIDTH'(1);
        end
      end else begin
        if (w_at_zero) begin
          w_tc_nxt  = 1'b1;
          w_ovf_nxt = 1'b1;
          w_c_nxt   = SATURATE ? '0 : MAX;
        end else begin
          w_c_nxt = r_c - WIDTH'(1);
        end
      end
    end
  end

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      r_c   <= '0;
      r_tc  <= 1'b0;
      r_ovf <= 1'b0;
    end else begin
      r_c   <= w_c_nxt;
      r_tc  <= w_tc_nxt;
      r_ovf <= w_ovf_nxt;
    end
  end

  assign C   = r_c;
  assign TC  = r_tc;
  assign OVF = r_ovf;

endmodule
